fifo_sync_top_module_2: RTL
===========================

FIFO_SYNC_TOP_MODULE_2 -- requirements
Module: fifo_sync_top_module_2

Interface
REQ-001 The block SHALL have parameter MEMORY_WIDTH, default 8: data word width in bits.
REQ-002 The block SHALL have parameter ADDRESS_SIZE, default 4: address width; DEPTH = 2**ADDRESS_SIZE.
REQ-003 The block SHALL have parameter ALMOST_FULL_THR, default 12: almost_full asserts at level >= this; legal range 1..DEPTH.
REQ-004 The block SHALL have parameter ALMOST_EMPTY_THR, default 2: almost_empty asserts at level <= this; legal range 0..DEPTH-1.
REQ-005 The block SHALL have parameter FWFT, default 0: 0 = registered read, 1 = first-word fall-through.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL be sampled on the rising clock edge.
REQ-007 The block SHALL have these ports:
 clk  in  1  sole clock
 rst  in  1  asynchronous, active-high reset
 w_en  in  1  write request
 wdata  in  MEMORY_WIDTH  write data
 r_en  in  1  read request
 clr_err  in  1  clears the sticky error flags
 rdata  out  MEMORY_WIDTH  read data
 rvalid  out  1  rdata holds valid data
 w_full  out  1  FIFO holds DEPTH words
 r_empty  out  1  FIFO holds 0 words
 almost_full  out  1  level >= ALMOST_FULL_THR
 almost_empty  out  1  level <= ALMOST_EMPTY_THR
 level  out  ADDRESS_SIZE+1  current word count, 0..DEPTH
 overflow  out  1  sticky: write attempted while full
 underflow  out  1  sticky: read attempted while empty

Function
REQ-008 Read and write pointers SHALL be ADDRESS_SIZE+1-bit binary counters; the low ADDRESS_SIZE bits SHALL address memory, and the MSB SHALL mark the wrap.
REQ-009 A write SHALL be accepted iff w_en & !w_full; an accepted write SHALL store wdata at w_addr and increment w_ptr.
REQ-010 A read SHALL be accepted iff r_en & !r_empty; an accepted read SHALL increment r_ptr.
REQ-011 w_full and r_empty SHALL be evaluated from the pre-edge state, so a write while full is rejected even with a simultaneous read, and a read while empty is rejected even with a simultaneous write.
REQ-012 level SHALL equal (w_ptr - r_ptr) mod 2**(ADDRESS_SIZE+1) and SHALL be registered.
REQ-013 An accepted write with an accepted read in the same cycle SHALL leave level unchanged.
REQ-014 w_full SHALL be level==DEPTH; r_empty SHALL be level==0; almost_full and almost_empty SHALL follow REQ-003/004; all four flags SHALL be derived from registered state only.
REQ-015 With FWFT=0, an accepted read SHALL load memory[r_addr] into the registered rdata and assert rvalid exactly one cycle after the read; rvalid SHALL be 0 otherwise, and rdata SHALL hold its value between reads.
REQ-016 With FWFT=1, rdata SHALL combinationally show memory[r_addr] and rvalid SHALL equal !r_empty; r_en SHALL act as the pop acknowledge.
REQ-017 overflow SHALL set on w_en & w_full; underflow SHALL set on r_en & r_empty; both SHALL clear on clr_err; if set and clear occur in the same cycle, set SHALL win.
REQ-018 Pointers SHALL wrap from 2**(ADDRESS_SIZE+1)-1 to 0 without disturbing flags or data.

Reset
REQ-019 While rst is high, outputs SHALL be: pointers 0, level 0, r_empty 1, w_full 0, almost_empty 1, almost_full 0, rvalid 0, rdata 0 (FWFT=0), overflow 0, underflow 0.
REQ-020 Memory contents SHALL NOT be reset; reset asserted mid-operation SHALL discard all stored words immediately.

Structure
REQ-021 The shared package fifo_pkg SHALL hold the default width/depth/threshold constants.
REQ-022 Pointer, level, flag and sticky-error logic SHALL live in sub-module fifo_sync_ptr_ctrl_2; memory and the read-data path SHALL stay in the top module.

Verification (MEMORY_WIDTH=8, ADDRESS_SIZE=4, defaults)
REQ-023 Write 0x01..0x10 (16 words), then read 16 -> data returned in order; w_full=1 at level 16; almost_full first asserts at level 12; r_empty=1 after the last read.
REQ-024 When full, pulse w_en with 0xAA -> write rejected, level stays 16, overflow=1 until clr_err.
REQ-025 When empty, assert r_en and clr_err in the same cycle -> underflow=1 (set wins), level stays 0, rvalid=0.
REQ-026 At level 5, hold w_en and r_en together for 40 cycles -> level stays 5, pointers wrap twice, and data order is preserved.
REQ-027 FWFT=0 vs FWFT=1, write 0x5A into an empty FIFO -> FWFT=1: rdata=0x5A and rvalid=1 one cycle after the write; FWFT=0: rdata=0x5A with rvalid=1 one cycle after r_en.
REQ-028 Assert rst at level 9 -> level 0, r_empty=1, and flags at reset values asynchronously; a subsequent write/read returns the new data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and status types for the synchronous FIFO slice.
package fifo_pkg;

    localparam int DEF_MEMORY_WIDTH     = 8;
    localparam int DEF_ADDRESS_SIZE     = 4;
    localparam int DEF_ALMOST_FULL_THR  = 12;
    localparam int DEF_ALMOST_EMPTY_THR = 2;
    localparam int DEF_FWFT             = 0;

    typedef struct packed {
        logic w_full;
        logic r_empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        w_full:       1'b0,
        r_empty:      1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

endpackage

// File: rtl/fifo_sync_ptr_ctrl_2.sv
// Pointer, level, status-flag and sticky-error control for the synchronous FIFO.
module fifo_sync_ptr_ctrl_2
    import fifo_pkg::*;
#(
    parameter int ADDRESS_SIZE     = DEF_ADDRESS_SIZE,
    parameter int ALMOST_FULL_THR  = DEF_ALMOST_FULL_THR,
    parameter int ALMOST_EMPTY_THR = DEF_ALMOST_EMPTY_THR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic                    r_en,
    input  logic                    clr_err,
    output logic [ADDRESS_SIZE-1:0] w_addr,
    output logic [ADDRESS_SIZE-1:0] r_addr,
    output logic                    w_accept,
    output logic                    r_accept,
    output logic [ADDRESS_SIZE:0]   level,
    output logic                    w_full,
    output logic                    r_empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int                DEPTH   = 2 ** ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0] DEPTH_L = (ADDRESS_SIZE + 1)'(DEPTH);
    localparam logic [ADDRESS_SIZE:0] AF_L    = (ADDRESS_SIZE + 1)'(ALMOST_FULL_THR);
    localparam logic [ADDRESS_SIZE:0] AE_L    = (ADDRESS_SIZE + 1)'(ALMOST_EMPTY_THR);
    localparam logic [ADDRESS_SIZE:0] ZERO_L  = {(ADDRESS_SIZE + 1){1'b0}};

    logic [ADDRESS_SIZE:0] w_ptr_r;
    logic [ADDRESS_SIZE:0] r_ptr_r;
    logic [ADDRESS_SIZE:0] level_r;
    fifo_flags_t           flags_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  w_accept_s;
    logic                  r_accept_s;
    logic [ADDRESS_SIZE:0] w_ptr_next_s;
    logic [ADDRESS_SIZE:0] r_ptr_next_s;
    logic [ADDRESS_SIZE:0] level_next_s;
    fifo_flags_t           flags_next_s;

    // Accept decisions and next-state pointers/level/flags from registered state.
    always_comb begin
        w_accept_s   = w_en & ~flags_r.w_full;
        r_accept_s   = r_en & ~flags_r.r_empty;
        w_ptr_next_s = w_ptr_r + {{ADDRESS_SIZE{1'b0}}, w_accept_s};
        r_ptr_next_s = r_ptr_r + {{ADDRESS_SIZE{1'b0}}, r_accept_s};
        // Modular subtraction keeps level correct across the MSB wrap.
        level_next_s = w_ptr_next_s - r_ptr_next_s;
        flags_next_s.w_full       = (level_next_s == DEPTH_L);
        flags_next_s.r_empty      = (level_next_s == ZERO_L);
        flags_next_s.almost_full  = (level_next_s >= AF_L);
        flags_next_s.almost_empty = (level_next_s <= AE_L);
    end

    // Pointer, level, flag and sticky-error registers; a set beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_r     <= ZERO_L;
            r_ptr_r     <= ZERO_L;
            level_r     <= ZERO_L;
            flags_r     <= FLAGS_RESET;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            w_ptr_r     <= w_ptr_next_s;
            r_ptr_r     <= r_ptr_next_s;
            level_r     <= level_next_s;
            flags_r     <= flags_next_s;
            overflow_r  <= (w_en & flags_r.w_full)  ? 1'b1 : (clr_err ? 1'b0 : overflow_r);
            underflow_r <= (r_en & flags_r.r_empty) ? 1'b1 : (clr_err ? 1'b0 : underflow_r);
        end
    end

    assign w_addr       = w_ptr_r[ADDRESS_SIZE-1:0];
    assign r_addr       = r_ptr_r[ADDRESS_SIZE-1:0];
    assign w_accept     = w_accept_s;
    assign r_accept     = r_accept_s;
    assign level        = level_r;
    assign w_full       = flags_r.w_full;
    assign r_empty      = flags_r.r_empty;
    assign almost_full  = flags_r.almost_full;
    assign almost_empty = flags_r.almost_empty;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: rtl/fifo_sync_top_module_2.sv
// Synchronous FIFO top: storage array and read-data path, with control in fifo_sync_ptr_ctrl_2.
module fifo_sync_top_module_2
    import fifo_pkg::*;
#(
    parameter int MEMORY_WIDTH     = DEF_MEMORY_WIDTH,
    parameter int ADDRESS_SIZE     = DEF_ADDRESS_SIZE,
    parameter int ALMOST_FULL_THR  = DEF_ALMOST_FULL_THR,
    parameter int ALMOST_EMPTY_THR = DEF_ALMOST_EMPTY_THR,
    parameter int FWFT             = DEF_FWFT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic [MEMORY_WIDTH-1:0] wdata,
    input  logic                    r_en,
    input  logic                    clr_err,
    output logic [MEMORY_WIDTH-1:0] rdata,
    output logic                    rvalid,
    output logic                    w_full,
    output logic                    r_empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [ADDRESS_SIZE:0]   level,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int DEPTH = 2 ** ADDRESS_SIZE;

    logic [MEMORY_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDRESS_SIZE-1:0] w_addr_s;
    logic [ADDRESS_SIZE-1:0] r_addr_s;
    logic                    w_accept_s;
    logic                    r_accept_s;

    fifo_sync_ptr_ctrl_2 #(
        .ADDRESS_SIZE     (ADDRESS_SIZE),
        .ALMOST_FULL_THR  (ALMOST_FULL_THR),
        .ALMOST_EMPTY_THR (ALMOST_EMPTY_THR)
    ) u_ptr_ctrl (
        .clk          (clk),
        .rst          (rst),
        .w_en         (w_en),
        .r_en         (r_en),
        .clr_err      (clr_err),
        .w_addr       (w_addr_s),
        .r_addr       (r_addr_s),
        .w_accept     (w_accept_s),
        .r_accept     (r_accept_s),
        .level        (level),
        .w_full       (w_full),
        .r_empty      (r_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Storage array; contents are deliberately left unreset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_accept_s) begin
            mem_r[w_addr_s] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata  = mem_r[r_addr_s];
            assign rvalid = ~r_empty;
        end else begin : g_registered
            logic [MEMORY_WIDTH-1:0] rdata_r;
            logic                    rvalid_r;

            // Registered read port: rdata updates only on an accepted read, rvalid pulses once.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_r  <= {MEMORY_WIDTH{1'b0}};
                    rvalid_r <= 1'b0;
                end else begin
                    rvalid_r <= r_accept_s;
                    if (r_accept_s) begin
                        rdata_r <= mem_r[r_addr_s];
                    end else begin
                        rdata_r <= rdata_r;
                    end
                end
            end

            assign rdata  = rdata_r;
            assign rvalid = rvalid_r;
        end
    endgenerate

endmodule
